// File: rtl/npu_ctrl_pkg.sv
// Shared NPU controller definitions: datapath widths and the controller state type.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package npu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } ctrl_state_e;

endpackage

// File: rtl/DotProduct.sv
// Combinational signed dot product: per-element products sign-extended to ACC_WIDTH,
// summed with two's-complement wrap.
module DotProduct #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0][`DATA_WIDTH-1:0] a,
    input  logic [N-1:0][`DATA_WIDTH-1:0] b,
    output logic signed [`ACC_WIDTH-1:0]  y
);

    logic signed [`ACC_WIDTH-1:0] prod [N];

    for (genvar i = 0; i < N; i++) begin : g_mul
        logic signed [`ACC_WIDTH-1:0] a_ext;
        logic signed [`ACC_WIDTH-1:0] b_ext;
        assign a_ext   = `ACC_WIDTH'($signed(a[i]));
        assign b_ext   = `ACC_WIDTH'($signed(b[i]));
        assign prod[i] = a_ext * b_ext;
    end

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y = y + prod[i];
        end
    end

endmodule

// File: rtl/matvec_controller.sv
// Streams ROWS weight rows against a captured activation vector, producing one
// dot-product result per row through a valid/ready output stage.
module matvec_controller
    import npu_ctrl_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ROWS = 4,
    localparam int unsigned IdxW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [N-1:0][`DATA_WIDTH-1:0] x_in,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [N-1:0][`DATA_WIDTH-1:0] w_row,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic signed [`ACC_WIDTH-1:0]  y_data,
    output logic [IdxW-1:0]               y_index,
    output logic                          busy,
    output logic                          done
);

    ctrl_state_e                   state_q, state_d;
    logic [N-1:0][`DATA_WIDTH-1:0] x_q, x_d;
    logic [IdxW-1:0]               row_cnt_q, row_cnt_d;
    logic                          y_valid_q, y_valid_d;
    logic signed [`ACC_WIDTH-1:0]  y_data_q, y_data_d;
    logic [IdxW-1:0]               y_index_q, y_index_d;
    logic                          done_q, done_d;
    logic signed [`ACC_WIDTH-1:0]  dot;
    logic                          row_xfer, y_hs, last_row;

    DotProduct #(.N(N)) u_dot (
        .a (x_q),
        .b (w_row),
        .y (dot)
    );

    assign w_ready  = (state_q == StRun) && (!y_valid_q || y_ready);
    assign row_xfer = w_valid && w_ready;
    assign y_hs     = y_valid_q && y_ready;
    assign last_row = (row_cnt_q == IdxW'(ROWS - 1));

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_index = y_index_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        row_cnt_d = row_cnt_q;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_index_d = y_index_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The done cycle itself is never an accepting cycle.
                if (start && !done_q) begin
                    x_d       = x_in;
                    row_cnt_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    y_valid_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    if (y_hs) begin
                        y_valid_d = 1'b0;
                    end
                    if (row_xfer) begin
                        y_data_d  = dot;
                        y_index_d = row_cnt_q;
                        y_valid_d = 1'b1;
                        if (last_row) begin
                            state_d = StDrain;
                        end else begin
                            row_cnt_d = row_cnt_q + IdxW'(1);
                        end
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    y_valid_d = 1'b0;
                    state_d   = StIdle;
                end else if (y_hs) begin
                    y_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            row_cnt_q <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_index_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            row_cnt_q <= row_cnt_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_index_q <= y_index_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/matvec_controller.md
MATVEC_CONTROLLER -- requirements
Module: matvec_controller

Interface
REQ-001 Parameter N, default 4, meaning vector dimensionality (elements per x vector and per weight row); SHALL be >= 1.
REQ-002 Parameter ROWS, default 4, meaning weight rows per job; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  job request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous job cancel.
REQ-007 x_in  input  N x signed `DATA_WIDTH`  activation vector; captured on an accepted start.
REQ-008 w_valid  input  1  weight row valid.
REQ-009 w_ready  output  1  controller accepts a weight row.
REQ-010 w_row  input  N x signed `DATA_WIDTH`  weight row.
REQ-011 y_valid  output  1  result valid.
REQ-012 y_ready  input  1  consumer accepts the result.
REQ-013 y_data  output  signed `ACC_WIDTH`  dot product of x and the current row.
REQ-014 y_index  output  $clog2(ROWS) bits, minimum 1  row index of y_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on job completion.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-018 IDLE: when start=1, x_in SHALL be registered into x_reg, row_cnt SHALL be cleared to 0, and the FSM SHALL go to RUN.
REQ-019 start SHALL be ignored outside IDLE; x_reg SHALL be stable from the accepting cycle until the FSM returns to IDLE.
REQ-020 w_ready SHALL equal (state==RUN) && (!y_valid || y_ready), combinationally.
REQ-021 A row transfer SHALL occur when w_valid && w_ready are both high in the same cycle.
REQ-022 On a row transfer, the next edge SHALL load y_data with the dot product of x_reg and w_row, load y_index with row_cnt, set y_valid=1 and increment row_cnt; result latency is 1 cycle.
REQ-023 Arithmetic SHALL match the shared DotProduct unit: signed products, sign-extended to `ACC_WIDTH`, summed with two's-complement wrap on overflow and no saturation.
REQ-024 y_valid, y_data and y_index SHALL hold stable while y_valid=1 && y_ready=0.
REQ-025 y_valid SHALL clear on a y handshake unless a new row transfers in the same cycle; with continuous valid/ready the throughput SHALL be one row per cycle.
REQ-026 The transfer of row ROWS-1 SHALL move the FSM to DRAIN; row_cnt SHALL NOT wrap past ROWS-1 and w_ready SHALL be 0 in DRAIN.
REQ-027 DRAIN: on the y handshake of the last result, done SHALL pulse high for exactly one cycle and the FSM SHALL return to IDLE.
REQ-028 A new start SHALL be accepted no earlier than the cycle after done.
REQ-029 abort=1 in RUN or DRAIN SHALL, at the next edge, clear y_valid, go to IDLE, and leave done low.
REQ-030 abort SHALL take priority over a simultaneous row transfer or y handshake; abort in IDLE SHALL have no effect, and start=1 with abort=1 in IDLE SHALL start the job.

Reset
REQ-031 rst=1 SHALL immediately force: state=IDLE, row_cnt=0, y_valid=0, y_data=0, y_index=0, done=0, busy=0, w_ready=0.
REQ-032 x_reg SHALL reset to all zeros.
REQ-033 Reset mid-job SHALL discard the job silently, with no done pulse.

Structure
REQ-034 DATA_WIDTH and ACC_WIDTH SHALL come from the shared width include; the state enum SHALL live in a shared package, npu_ctrl_pkg.
REQ-035 The existing DotProduct module SHALL be instantiated once as the only sub-module, with x_reg and w_row as its inputs; the controller SHALL add no other arithmetic.

Verification
REQ-036 Scenario: N=4, ROWS=4, x={1,2,3,4}, rows {1,1,1,1}, {-1,0,0,0}, {0,0,0,2}, {2,2,2,2}, with w_valid=y_ready=1 throughout -> y_data 10, -1, 8, 20 with y_index 0..3 on consecutive cycles, then done high for one cycle.
REQ-037 Scenario: hold y_ready=0 for 3 cycles after the first result -> w_ready=0 and y_data/y_index stable for those cycles, with no lost or duplicated row.
REQ-038 Scenario: x={127,127,127,127}, row={127,127,127,127} -> y_data=64516; x={-128 in all elements}, row={127 in all elements} -> y_data=-65024.
REQ-039 Scenario: abort asserted after row 1 is transferred -> the next cycle shows IDLE, y_valid=0, busy=0, no done; a new start then runs correctly from index 0.
REQ-040 Scenario: rst asserted asynchronously in mid-RUN between clock edges -> all outputs reach their reset values before the next edge.
REQ-041 Scenario: start pulsed during RUN with a different x_in -> ignored; results still use the original x.
